// File: rtl/complex_result_serializer_if.sv
// Handshake bundle between the multiplier result port, the serializer and the narrow sink.
// Signal names keep the block's published port names so checkers can bind to them directly.
interface complex_result_serializer_if #(
  parameter int WIDTH = 64,
  parameter int SIZE  = 16
);
  localparam int IW = $clog2(SIZE);

  // Valid/ready: a transfer happens on a rising edge where both valid and ready are high;
  // valid never waits on ready, and payload is held stable while valid is high and ready is low.
  logic                            in_valid_i;
  logic                            in_ready_o;
  logic [2*SIZE-1:0][WIDTH-1:0]    result_i;
  logic                            out_valid_o;
  logic                            out_ready_i;
  logic [WIDTH-1:0]                out_real_o;
  logic [WIDTH-1:0]                out_imag_o;
  logic [IW-1:0]                   out_index_o;
  logic                            out_last_o;
  logic                            busy_o;

  modport master (
    output in_valid_i, result_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_real_o, out_imag_o, out_index_o, out_last_o, busy_o
  );

  modport slave (
    input  in_valid_i, result_i, out_ready_i,
    output in_ready_o, out_valid_o, out_real_o, out_imag_o, out_index_o, out_last_o, busy_o
  );
endinterface

// File: rtl/complex_result_serializer.sv
// Buffers one wide complex result bundle and streams it out as SIZE (real, imag) beats.
// A new bundle may be accepted on the cycle the last beat leaves, giving gap-free streaming.
module complex_result_serializer #(
  parameter int WIDTH = 64,
  parameter int SIZE  = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  complex_result_serializer_if.slave    bus,
  output logic                          state_o
);
  localparam int IW = $clog2(SIZE);
  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE - 1);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             index_q, index_d;
  logic                      load;
  logic                      in_ready;
  logic                      out_valid;
  logic                      last_beat;
  logic                      out_fire;
  logic                      in_fire;
  logic [SIZE-1:0][WIDTH-1:0] re_q;
  logic [SIZE-1:0][WIDTH-1:0] im_q;

  assign out_valid = (state_q == STREAM);
  assign last_beat = out_valid && (index_q == LAST_IDX);
  assign out_fire  = out_valid && bus.out_ready_i;
  assign in_fire   = bus.in_valid_i && in_ready;

  always_comb begin
    in_ready = ~rst_i & ((state_q == IDLE) | (out_fire & last_beat));
    state_d  = state_q;
    index_d  = index_q;
    load     = 1'b0;
    // Flush wins over a same-cycle accept: ready is still reported but nothing is captured.
    if (flush_i) begin
      state_d = IDLE;
      index_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_fire) begin
            state_d = STREAM;
            index_d = '0;
            load    = 1'b1;
          end
        end
        STREAM: begin
          if (out_fire) begin
            if (last_beat) begin
              index_d = '0;
              if (in_fire) begin
                load = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end else begin
              index_d = index_q + IW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          index_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      index_q <= '0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      if (load) begin
        for (int k = 0; k < SIZE; k++) begin
          re_q[k] <= bus.result_i[2*k];
          im_q[k] <= bus.result_i[2*k+1];
        end
      end
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_last_o  = last_beat;
  assign bus.out_index_o = index_q;
  assign bus.out_real_o  = re_q[index_q];
  assign bus.out_imag_o  = im_q[index_q];
  assign bus.busy_o      = (state_q == STREAM);
  assign state_o         = state_q;
endmodule
